// File: rtl/mpt_plb.sv
// mpt_plb - fully associative Protection Lookaside Buffer for MPT walk results.
//
// Caches permission results keyed by {SDID, SPA[PLEN-1:12]} with mixed
// 4 KiB / 2 MiB / 1 GiB granules. Lookups answer one cycle after the request;
// the MPT walker fills entries on a miss; flushes can target everything,
// one SDID, or one SDID+address.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   lookup_valid_i/sdid/spa/access   lookup request (access: 0 none,1 R,2 W,3 X)
//   lookup_valid_o/hit/perm/allow    registered lookup result
//   fill_valid_i/sdid/spa/level/perm walker fill (level 3 is ignored)
//   flush_i/mode/sdid/spa    flush (mode 0 all, 1 SDID, 2 SDID+addr, 3 no-op)
//   flush_done_o             pulse one cycle after any flush request
//
// Optional feature macro: MPT_PLB_PERF_CNT_EN adds saturating hit_cnt_o,
// miss_cnt_o and evict_cnt_o counters (CNT_W bits each).

module mpt_plb #(
    parameter int NUM_ENTRIES = 16,
    parameter int PLEN        = 56,
    parameter int SDID_LEN    = 6,
    parameter int CNT_W       = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                lookup_valid_i,
    input  logic [SDID_LEN-1:0] lookup_sdid_i,
    input  logic [PLEN-1:0]     lookup_spa_i,
    input  logic [1:0]          lookup_access_i,
    output logic                lookup_valid_o,
    output logic                lookup_hit_o,
    output logic [1:0]          lookup_perm_o,
    output logic                lookup_allow_o,
    input  logic                fill_valid_i,
    input  logic [SDID_LEN-1:0] fill_sdid_i,
    input  logic [PLEN-1:0]     fill_spa_i,
    input  logic [1:0]          fill_level_i,
    input  logic [1:0]          fill_perm_i,
    input  logic                flush_i,
    input  logic [1:0]          flush_mode_i,
    input  logic [SDID_LEN-1:0] flush_sdid_i,
    input  logic [PLEN-1:0]     flush_spa_i,
    output logic                flush_done_o
`ifdef MPT_PLB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    hit_cnt_o,
    output logic [CNT_W-1:0]    miss_cnt_o,
    output logic [CNT_W-1:0]    evict_cnt_o
`endif
);

    localparam int TAG_W = PLEN - 12;
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    // Tag bits that take part in a compare for a given granule level.
    function automatic logic [TAG_W-1:0] level_mask(input logic [1:0] lvl);
        logic [TAG_W-1:0] m;
        m = '1;
        if (lvl == 2'd1) m[8:0]  = '0;
        if (lvl == 2'd2) m[17:0] = '0;
        return m;
    endfunction

    function automatic logic perm_allows(input logic [1:0] acc, input logic [1:0] perm);
        logic ok;
        case (acc)
            2'd1:    ok = (perm != 2'd0);
            2'd2:    ok = (perm == 2'd2) || (perm == 2'd3);
            2'd3:    ok = (perm == 2'd1) || (perm == 2'd3);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [SDID_LEN-1:0]    sdid_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_q   [NUM_ENTRIES];
    logic [1:0]             level_q [NUM_ENTRIES];
    logic [1:0]             perm_q  [NUM_ENTRIES];
    logic [IDX_W-1:0]       rr_ptr_q;

    logic [TAG_W-1:0]       lu_tag, fill_tag, flush_tag;
    logic [NUM_ENTRIES-1:0] lu_match, flush_clr;
    logic                   lu_hit;
    logic [1:0]             lu_perm;
    logic                   exact_found, free_found, use_rr, fill_ok;
    logic [IDX_W-1:0]       exact_idx, free_idx, victim_idx;

    assign lu_tag    = lookup_spa_i[PLEN-1:12];
    assign fill_tag  = fill_spa_i[PLEN-1:12] & level_mask(fill_level_i);
    assign flush_tag = flush_spa_i[PLEN-1:12];
    // A simultaneous flush drops the fill.
    assign fill_ok   = fill_valid_i && (fill_level_i != 2'd3) && !flush_i;

    // Lookup compare; scanning downwards leaves the lowest matching index as winner.
    always_comb begin
        lu_match = '0;
        lu_hit   = 1'b0;
        lu_perm  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            lu_match[i] = valid_q[i] && (sdid_q[i] == lookup_sdid_i) &&
                          (((tag_q[i] ^ lu_tag) & level_mask(level_q[i])) == '0);
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (lu_match[i]) begin
                lu_hit  = 1'b1;
                lu_perm = perm_q[i];
            end
        end
    end

    // Fill victim: identical entry first, then lowest free slot, then round-robin.
    always_comb begin
        exact_found = 1'b0;
        exact_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (sdid_q[i] == fill_sdid_i) && (level_q[i] == fill_level_i) &&
                (tag_q[i] == fill_tag)) begin
                exact_found = 1'b1;
                exact_idx   = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        use_rr     = !exact_found && !free_found;
        victim_idx = exact_found ? exact_idx : (free_found ? free_idx : rr_ptr_q);
    end

    // Entries cleared by the current flush request; mode 2 uses each entry's own granule.
    always_comb begin
        flush_clr = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            case (flush_mode_i)
                2'd0:    flush_clr[i] = 1'b1;
                2'd1:    flush_clr[i] = (sdid_q[i] == flush_sdid_i);
                2'd2:    flush_clr[i] = (sdid_q[i] == flush_sdid_i) &&
                                        (((tag_q[i] ^ flush_tag) & level_mask(level_q[i])) == '0);
                default: flush_clr[i] = 1'b0;
            endcase
        end
    end

    // Entry storage, replacement pointer and registered lookup/flush outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q        <= '0;
            rr_ptr_q       <= '0;
            lookup_valid_o <= 1'b0;
            lookup_hit_o   <= 1'b0;
            lookup_perm_o  <= '0;
            lookup_allow_o <= 1'b0;
            flush_done_o   <= 1'b0;
        end else begin
            lookup_valid_o <= lookup_valid_i;
            flush_done_o   <= flush_i;
            if (lookup_valid_i && !flush_i && lu_hit) begin
                lookup_hit_o   <= 1'b1;
                lookup_perm_o  <= lu_perm;
                lookup_allow_o <= perm_allows(lookup_access_i, lu_perm);
            end else begin
                lookup_hit_o   <= 1'b0;
                lookup_perm_o  <= '0;
                lookup_allow_o <= 1'b0;
            end
            if (flush_i) begin
                valid_q <= valid_q & ~flush_clr;
            end else if (fill_ok) begin
                valid_q[victim_idx] <= 1'b1;
                sdid_q[victim_idx]  <= fill_sdid_i;
                tag_q[victim_idx]   <= fill_tag;
                level_q[victim_idx] <= fill_level_i;
                perm_q[victim_idx]  <= fill_perm_i;
                if (use_rr) begin
                    rr_ptr_q <= rr_ptr_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

`ifdef MPT_PLB_PERF_CNT_EN
    logic lu_counted_hit, lu_counted_miss;
    assign lu_counted_hit  = lookup_valid_i && !flush_i && lu_hit;
    assign lu_counted_miss = lookup_valid_i && !(!flush_i && lu_hit);

    // Saturating performance counters; flushes leave them alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hit_cnt_o   <= '0;
            miss_cnt_o  <= '0;
            evict_cnt_o <= '0;
        end else begin
            if (lu_counted_hit && (hit_cnt_o != '1))
                hit_cnt_o <= hit_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
            if (lu_counted_miss && (miss_cnt_o != '1))
                miss_cnt_o <= miss_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
            if (fill_ok && use_rr && (evict_cnt_o != '1))
                evict_cnt_o <= evict_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

    // The page offset never takes part in matching.
    logic unused_offset;
    assign unused_offset = ^{lookup_spa_i[11:0], fill_spa_i[11:0], flush_spa_i[11:0]};

endmodule

// File: doc/mpt_plb.md
Name: mpt_plb

Overview:
- Parametrised, fully associative Protection Lookaside Buffer (PLB) that caches MPT walk results, keyed by supervisor domain ID (SDID) and supervisor physical address (SPA).
- Generalises the single-size PLB entry to mixed 4 KiB / 2 MiB / 1 GiB granules, configurable depth and widths, plus per-SDID and per-address flush.
- Sits between the core's physical access path and the MPT walker: lookups are answered in one cycle; on a miss the walker fills the buffer.

Parameters:
- NUM_ENTRIES, 16, number of entries; power of 2, at least 2.
- PLEN, 56, SPA width in bits (34 for RV32 builds).
- SDID_LEN, 6, SDID width.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- lookup_valid_i  in  1  lookup request
- lookup_sdid_i  in  SDID_LEN  domain of the request
- lookup_spa_i  in  PLEN  physical address
- lookup_access_i  in  2  access type: NONE=0, READ=1, WRITE=2, EXEC=3
- lookup_valid_o  out  1  result valid, one cycle after the request
- lookup_hit_o  out  1  a matching entry was found
- lookup_perm_o  out  2  permission: DISALLOWED=0, RX=1, RW=2, RWX=3
- lookup_allow_o  out  1  access permitted (meaningful only on a hit)
- fill_valid_i  in  1  write a walk result
- fill_sdid_i  in  SDID_LEN  domain of the fill
- fill_spa_i  in  PLEN  address of the fill
- fill_level_i  in  2  granule: 0=4K, 1=2M, 2=1G, 3=reserved (fill ignored)
- fill_perm_i  in  2  permission of the fill
- flush_i  in  1  flush request (single-cycle pulse)
- flush_mode_i  in  2  0=all, 1=by SDID, 2=by SDID+address, 3=no-op
- flush_sdid_i  in  SDID_LEN  flush SDID
- flush_spa_i  in  PLEN  flush address
- flush_done_o  out  1  one-cycle pulse the cycle after a flush

Behaviour:
- Reset (rst_ni=0 at a clock edge): all entry valid bits cleared; replacement pointer set to 0. lookup_valid_o, lookup_hit_o, lookup_allow_o, flush_done_o = 0. lookup_perm_o = 0.
- Entry contents: valid bit, SDID, tag = SPA[PLEN-1:12], level, perm.
- Match rule: valid, and SDID equal, and tag equal under a level mask.
  - 4K: full tag compared.
  - 2M: SPA[20:12] ignored.
  - 1G: SPA[29:12] ignored.
- Lookup latency: 1 cycle; all outputs registered.
  - lookup_valid_o mirrors lookup_valid_i delayed by one cycle.
  - lookup_hit_o, lookup_perm_o and lookup_allow_o are 0 whenever lookup_valid_o is 0.
- Multiple matches (only possible when granules overlap): the lowest index wins.
- lookup_allow_o on a hit:
  - READ: perm != DISALLOWED.
  - WRITE: perm is RW or RWX.
  - EXEC: perm is RX or RWX.
  - NONE: 0.
- On a miss: lookup_perm_o = 0 and lookup_allow_o = 0.
- Fill, written at the clock edge; victim selection:
  - (a) If an entry matches with identical SDID, tag and level, overwrite it in place.
  - (b) Otherwise, the lowest-index invalid entry.
  - (c) Otherwise, the entry at the round-robin pointer; the pointer then increments and wraps from NUM_ENTRIES-1 to 0. The pointer advances only on case (c).
- Flush, applied at the clock edge:
  - Mode 0: clear every valid bit.
  - Mode 1: clear entries whose SDID equals flush_sdid_i.
  - Mode 2: clear entries that match {flush_sdid_i, flush_spa_i} under each entry's own level mask.
  - flush_done_o pulses the next cycle for all modes, including mode 3.
- Simultaneous events:
  - Flush and fill in the same cycle: flush wins and the fill is dropped.
  - Lookup in the same cycle as a flush returns miss.
  - Lookup in the same cycle as a fill sees the pre-fill contents.
- Reset during an outstanding lookup: lookup_valid_o is 0 in the following cycle and the result is lost.

Optional Feature:
- MPT_PLB_PERF_CNT_EN defined:
  - Adds outputs hit_cnt_o [CNT_W], miss_cnt_o [CNT_W] and evict_cnt_o [CNT_W].
  - Each counter increments on a registered hit, on a registered miss, or on a case-(c) fill respectively.
  - Counters saturate at all-ones, are cleared by reset, and are not cleared by flush.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then lookup SDID=1, SPA=0x1000, READ -> next cycle lookup_valid_o=1, hit=0, perm=0, allow=0.
- Fill SDID=1, SPA=0x4000_0000, level=1G, perm=RX; lookup SPA=0x7FFF_F123 with EXEC, then WRITE -> hit=1, allow=1, then hit=1, allow=0; lookup with SDID=2 -> miss.
- Fill 16 distinct 4K pages (entries 0..15), then a 17th -> the 17th replaces entry 0 and the pointer becomes 1; the 18th replaces entry 1; looking up the first page -> miss.
- Fill SDID=3 at SPA 0x2000 and SDID=4 at SPA 0x2000; flush mode 1 with SDID=3 -> flush_done_o=1 the next cycle; SDID=3 misses, SDID=4 hits.
- In the same cycle: fill SDID=5, SPA=0x3000, plus flush mode 0 plus a lookup of an existing entry -> the lookup misses and a later lookup of 0x3000 misses (fill dropped).
- With MPT_PLB_PERF_CNT_EN defined: 3 hits, 2 misses and 1 eviction -> hit_cnt_o=3, miss_cnt_o=2, evict_cnt_o=1; counters unchanged after a flush.
